// File: rtl/imem_fetch_arbiter_pkg.sv
// Shared types for the instruction-memory fetch arbiter and its round-robin core.
package imem_arb_pkg;

  localparam int MAX_REQ = 4;

  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// Fetch-side and imem-side signal bundle; slave is the arbiter, master is the cores plus memory.
interface imem_fetch_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        flush;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    mem_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_rdata;

  modport slave (
    input  req_valid, req_addr, flush, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_en, mem_addr
  );

  modport master (
    output req_valid, req_addr, flush, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_en, mem_addr
  );
endinterface

// File: rtl/imem_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping; zero latency.
module rr_arbiter
  import imem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  req_id_t      ptr,
  output logic [N-1:0] gnt,
  output req_id_t      gnt_id,
  output logic         any
);

  int best_d;
  int d;

  // Distance from ptr in wrap order; the smallest distance wins.
  always_comb begin
    best_d = N;
    d      = 0;
    gnt_id = '0;
    gnt    = '0;
    for (int j = 0; j < N; j++) begin
      d = (j - int'(ptr) + N) % N;
      if (req[j] && (d < best_d)) begin
        best_d = d;
        gnt_id = req_id_t'(j);
      end
    end
    any = (best_d < N);
    for (int j = 0; j < N; j++) begin
      gnt[j] = any && (gnt_id == req_id_t'(j));
    end
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one imem port among N_REQ fetch stages; one grant per cycle, response MEM_LAT cycles later.
// Responses are never stalled; flushed cores are masked from arbitration and their in-flight reads dropped.
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  imem_fetch_arbiter_if.slave bus
);

  logic [N_REQ-1:0]   cand;
  logic [N_REQ-1:0]   gnt;
  req_id_t            gnt_id;
  req_id_t            rr_ptr;
  logic               any;
  logic               accept;
  logic [MAX_REQ-1:0] flush_ext;
  tag_t               pipe [MEM_LAT];
  tag_t               rsp_tag;

  assign cand = bus.req_valid & ~bus.flush;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req    (cand),
    .ptr    (rr_ptr),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  assign accept        = any & ~rst;
  assign bus.mem_en    = accept;
  assign bus.req_ready = rst ? '0 : gnt;

  always_comb begin
    bus.mem_addr = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (gnt[j]) bus.mem_addr = bus.req_addr[j*ADDR_W +: ADDR_W];
    end
  end

  // Widened so a tag id can index it regardless of N_REQ.
  always_comb begin
    flush_ext = '0;
    for (int j = 0; j < N_REQ; j++) flush_ext[j] = bus.flush[j];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      for (int k = 0; k < MEM_LAT; k++) pipe[k] <= '0;
    end else begin
      if (accept) rr_ptr <= (gnt_id == req_id_t'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
      pipe[0] <= '{valid: accept, id: gnt_id};
      for (int k = 1; k < MEM_LAT; k++) begin
        pipe[k].valid <= pipe[k-1].valid & ~flush_ext[pipe[k-1].id];
        pipe[k].id    <= pipe[k-1].id;
      end
    end
  end

  assign rsp_tag      = pipe[MEM_LAT-1];
  assign bus.rsp_data = bus.mem_rdata;

  // The last stage is cleared by flush only at the next edge, so suppress it here too.
  always_comb begin
    bus.rsp_valid = '0;
    for (int j = 0; j < N_REQ; j++) begin
      bus.rsp_valid[j] = ~rst & rsp_tag.valid & (rsp_tag.id == req_id_t'(j)) & ~bus.flush[j];
    end
  end

endmodule
